// File: rtl/score_ctrl_if.sv
// Bundle of frame/input strobes and score/state outputs exchanged between
// the game logic and score_ctrl.
interface score_ctrl_if;
  logic       i_frame_tick;
  logic       i_move;
  logic       i_collision;
  logic       i_restart;
  logic [6:0] o_score;
  logic [3:0] o_tens;
  logic [3:0] o_ones;
  logic [6:0] o_high_score;
  logic [1:0] o_state;
  logic       o_inc_pulse;

  modport master (
    output i_frame_tick, i_move, i_collision, i_restart,
    input  o_score, o_tens, o_ones, o_high_score, o_state, o_inc_pulse
  );

  modport slave (
    input  i_frame_tick, i_move, i_collision, i_restart,
    output o_score, o_tens, o_ones, o_high_score, o_state, o_inc_pulse
  );
endinterface

// File: rtl/score_ctrl.sv
// Banner score sequencer: frame-gated, move-paced score with BCD digits,
// IDLE/RUN/OVER game state and a session high score.
module score_ctrl #(
  parameter int unsigned STEP_FRAMES = 8,
  parameter int unsigned MAX_SCORE   = 99
) (
  input logic        i_clk,
  input logic        i_rst,
  score_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] score_q, score_d;
  logic [3:0] tens_q,  tens_d;
  logic [3:0] ones_q,  ones_d;
  logic [6:0] high_q,  high_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       inc_q,   inc_d;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    high_d  = high_q;
    cnt_d   = cnt_q;
    inc_d   = 1'b0;

    if (bus.i_frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (bus.i_move) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.i_collision) begin
            state_d = ST_OVER;
            cnt_d   = '0;
            if (score_q > high_q) high_d = score_q;
          end else if (!bus.i_move) begin
            cnt_d = '0;
          end else if (cnt_q == 8'(STEP_FRAMES - 1)) begin
            cnt_d = '0;
            if (score_q < 7'(MAX_SCORE)) begin
              score_d = score_q + 7'd1;
              inc_d   = 1'b1;
              // BCD tracked incrementally so no divider is needed
              if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
              end else begin
                ones_d = ones_q + 4'd1;
              end
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_OVER: begin
          if (bus.i_restart) begin
            state_d = ST_IDLE;
            score_d = '0;
            tens_d  = '0;
            ones_d  = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      high_q  <= '0;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      high_q  <= high_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
    end
  end

  assign bus.o_score      = score_q;
  assign bus.o_tens       = tens_q;
  assign bus.o_ones       = ones_q;
  assign bus.o_high_score = high_q;
  assign bus.o_state      = state_q;
  assign bus.o_inc_pulse  = inc_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl: one instance with STEP_FRAMES=8, one with 1.
module tb_score_ctrl;

  logic clk = 1'b0;
  logic rst8 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  score_ctrl_if if8 ();
  score_ctrl_if if1 ();

  score_ctrl #(.STEP_FRAMES(8), .MAX_SCORE(99)) u8 (.i_clk(clk), .i_rst(rst8), .bus(if8));
  score_ctrl #(.STEP_FRAMES(1), .MAX_SCORE(99)) u1 (.i_clk(clk), .i_rst(rst1), .bus(if1));

  typedef struct packed {
    logic [6:0] score;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] high;
    logic [1:0] st;
    logic       inc;
  } obs_t;

  typedef struct packed {
    int st;
    int score;
    int high;
    int cnt;
    int inc;
  } mdl_t;

  obs_t q8[$];
  obs_t q1[$];
  mdl_t m8, m1;
  int   checks = 0;
  int   failures = 0;
  int   pulses8 = 0;
  int   pulses1 = 0;
  string phase = "init";

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 0; r.score = 0; r.high = 0; r.cnt = 0; r.inc = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_tick(mdl_t m, int step, bit mv, bit co, bit rs);
    mdl_t n = m;
    n.inc = 0;
    case (m.st)
      0: begin
        n.cnt = 0;
        if (mv) n.st = 1;
      end
      1: begin
        if (co) begin
          n.st = 2;
          n.cnt = 0;
          n.high = (m.score > m.high) ? m.score : m.high;
        end else if (!mv) n.cnt = 0;
        else if (m.cnt == step - 1) begin
          n.cnt = 0;
          if (m.score < 99) begin
            n.score = m.score + 1;
            n.inc = 1;
          end
        end else n.cnt = m.cnt + 1;
      end
      2: if (rs) begin
        n.st = 0; n.score = 0; n.cnt = 0;
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  function automatic obs_t to_obs(mdl_t m);
    obs_t o;
    o.score = 7'(m.score);
    o.tens  = 4'(m.score / 10);
    o.ones  = 4'(m.score % 10);
    o.high  = 7'(m.high);
    o.st    = 2'(m.st);
    o.inc   = (m.inc != 0);
    return o;
  endfunction

  // Monitors: one expected entry is pushed per cycle of interest
  always @(negedge clk) begin
    if (q8.size() > 0) begin
      obs_t e, a;
      e = q8.pop_front();
      a = {if8.o_score, if8.o_tens, if8.o_ones, if8.o_high_score, if8.o_state, if8.o_inc_pulse};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL dut8[%s] act score=%0d tens=%0d ones=%0d high=%0d st=%0d inc=%0d exp score=%0d tens=%0d ones=%0d high=%0d st=%0d inc=%0d",
                 phase, a.score, a.tens, a.ones, a.high, a.st, a.inc, e.score, e.tens, e.ones, e.high, e.st, e.inc);
      end
      if (if8.o_inc_pulse === 1'b1) pulses8++;
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      obs_t e, a;
      e = q1.pop_front();
      a = {if1.o_score, if1.o_tens, if1.o_ones, if1.o_high_score, if1.o_state, if1.o_inc_pulse};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL dut1[%s] act score=%0d tens=%0d ones=%0d high=%0d st=%0d inc=%0d exp score=%0d tens=%0d ones=%0d high=%0d st=%0d inc=%0d",
                 phase, a.score, a.tens, a.ones, a.high, a.st, a.inc, e.score, e.tens, e.ones, e.high, e.st, e.inc);
      end
      if (if1.o_inc_pulse === 1'b1) pulses1++;
    end
  end

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset(bit sel8);
    if (sel8) rst8 = 1'b1; else rst1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (sel8) begin m8 = mdl_reset(); q8.push_back(to_obs(m8)); end
      else      begin m1 = mdl_reset(); q1.push_back(to_obs(m1)); end
    end
    if (sel8) rst8 = 1'b0; else rst1 = 1'b0;
  endtask

  // One tick cycle followed by one quiet cycle; both are scored
  task automatic tick(bit sel8, bit mv, bit co, bit rs);
    if (sel8) begin
      if8.i_move = mv; if8.i_collision = co; if8.i_restart = rs; if8.i_frame_tick = 1'b1;
    end else begin
      if1.i_move = mv; if1.i_collision = co; if1.i_restart = rs; if1.i_frame_tick = 1'b1;
    end
    @(posedge clk); #1;
    if (sel8) begin
      if8.i_frame_tick = 1'b0;
      m8 = mdl_tick(m8, 8, mv, co, rs);
      q8.push_back(to_obs(m8));
    end else begin
      if1.i_frame_tick = 1'b0;
      m1 = mdl_tick(m1, 1, mv, co, rs);
      q1.push_back(to_obs(m1));
    end
    @(posedge clk); #1;
    if (sel8) begin m8.inc = 0; q8.push_back(to_obs(m8)); end
    else      begin m1.inc = 0; q1.push_back(to_obs(m1)); end
  endtask

  task automatic ticks(bit sel8, int n, bit mv);
    for (int i = 0; i < n; i++) tick(sel8, mv, 1'b0, 1'b0);
  endtask

  initial begin
    if8.i_frame_tick = 1'b0; if8.i_move = 1'b0; if8.i_collision = 1'b0; if8.i_restart = 1'b0;
    if1.i_frame_tick = 1'b0; if1.i_move = 1'b0; if1.i_collision = 1'b0; if1.i_restart = 1'b0;
    m8 = mdl_reset();
    m1 = mdl_reset();

    phase = "reset_idle";
    do_reset(1'b1);
    pulses8 = 0;
    ticks(1'b1, 20, 1'b0);
    check_val("idle_pulses", pulses8, 0);
    check_val("idle_state", int'(if8.o_state), 0);

    phase = "paced";
    pulses8 = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(1'b1, 24, 1'b1);
    check_val("paced_pulses", pulses8, 3);
    check_val("paced_score", int'(if8.o_score), 3);
    check_val("paced_ones", int'(if8.o_ones), 3);

    phase = "hold_break";
    do_reset(1'b1);
    pulses8 = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(1'b1, 7, 1'b1);
    ticks(1'b1, 1, 1'b0);
    ticks(1'b1, 7, 1'b1);
    check_val("break_score", int'(if8.o_score), 0);
    check_val("break_pulses", pulses8, 0);

    phase = "collision";
    do_reset(1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1'b0, 9, 1'b1);
    check_val("carry_pre_ones", int'(if1.o_ones), 9);
    ticks(1'b0, 1, 1'b1);
    check_val("carry_tens", int'(if1.o_tens), 1);
    check_val("carry_ones", int'(if1.o_ones), 0);
    ticks(1'b0, 2, 1'b1);
    pulses1 = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("coll_state", int'(if1.o_state), 2);
    check_val("coll_score", int'(if1.o_score), 12);
    check_val("coll_high", int'(if1.o_high_score), 12);
    check_val("coll_pulses", pulses1, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("restart_state", int'(if1.o_state), 0);
    check_val("restart_high", int'(if1.o_high_score), 12);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1'b0, 5, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("game2_score", int'(if1.o_score), 5);
    check_val("game2_high", int'(if1.o_high_score), 12);

    phase = "saturate";
    do_reset(1'b0);
    pulses1 = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1'b0, 105, 1'b1);
    check_val("sat_score", int'(if1.o_score), 99);
    check_val("sat_tens", int'(if1.o_tens), 9);
    check_val("sat_ones", int'(if1.o_ones), 9);
    check_val("sat_pulses", pulses1, 99);

    phase = "mid_reset";
    do_reset(1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1'b0, 40, 1'b1);
    check_val("pre_rst_score", int'(if1.o_score), 40);
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    m1 = mdl_reset();
    q1.push_back(to_obs(m1));
    check_val("rst_score", int'(if1.o_score), 0);
    check_val("rst_state", int'(if1.o_state), 0);
    @(posedge clk); #1;
    q1.push_back(to_obs(m1));

    @(posedge clk); #1;
    check_val("queues_drained", q8.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_ctrl.md
# score_ctrl

Game-side controller that sequences the score shown in the top banner. It gates score increments to frame boundaries so the renderer never sees a value change mid-frame. It paces increments while the player holds the move button and saturates at the two-digit display limit. It also runs the IDLE/RUN/OVER game state and tracks a session high score. It feeds the banner renderer's 7-bit score input and exposes BCD digits plus game state to the rest of the top level.

## Interface
- STEP_FRAMES, 8: frame ticks of continuous move-hold per score increment; legal range 1..255.
- MAX_SCORE, 99: saturation value; must be ≤ 99 so the value fits two display digits and 7 bits.
- i_clk  in  1  pixel clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_frame_tick  in  1  single-cycle pulse once per frame, asserted after the last visible line.
- i_move  in  1  move button, level, already debounced.
- i_collision  in  1  level or pulse; player hit an obstacle.
- i_restart  in  1  level or pulse; request a new game.
- o_score  out  7  current score, binary, 0..MAX_SCORE.
- o_tens  out  4  BCD tens digit of o_score.
- o_ones  out  4  BCD ones digit of o_score.
- o_high_score  out  7  best score since reset, binary.
- o_state  out  2  game state: 00 IDLE, 01 RUN, 10 OVER.
- o_inc_pulse  out  1  one-cycle pulse in the cycle o_score increments.

## Operation
- Single clock; all outputs registered. On i_rst: o_score=0, o_tens=0, o_ones=0, o_high_score=0, o_state=IDLE, o_inc_pulse=0, internal frame counter=0.
- All state changes, score updates and counter updates happen only on cycles with i_frame_tick=1. Other cycles hold every register, except o_inc_pulse, which returns to 0.
- IDLE: on tick with i_move=1, go to RUN. Frame counter =0. Score is not incremented on this tick.
- RUN, on each tick, highest priority first:
  - i_collision=1: go to OVER. o_high_score = max(o_high_score, o_score). No increment. Frame counter cleared.
  - i_move=0: frame counter cleared to 0.
  - i_move=1 and counter=STEP_FRAMES-1: counter is set to 0. If o_score<MAX_SCORE, o_score+1, BCD updated and o_inc_pulse=1. If o_score=MAX_SCORE, the score holds and no pulse is issued.
  - i_move=1 otherwise: counter+1.
- i_restart is ignored in RUN.
- OVER: score frozen. On tick with i_restart=1, go to IDLE and clear o_score, o_tens, o_ones and the counter. o_high_score is retained. i_collision and i_move are ignored.
- BCD is maintained incrementally, with no divider:
  - ones 9→0 carries into tens+1;
  - otherwise ones+1.
  - Invariant: o_score == 10*o_tens + o_ones at all times.
- o_high_score clears only on i_rst.
- With STEP_FRAMES=1, every held tick increments the score.
- Illegal o_state encoding 11 goes to IDLE on the next tick.

## Timing
- Latency: a tick sampled in cycle N produces updated outputs visible in cycle N+1. o_inc_pulse is high for exactly that one cycle.
- Inputs are sampled only in the tick cycle. Pulses on i_collision or i_restart that fall outside a tick are lost. Upstream must stretch them to span a tick.
- In RUN with i_move continuously high from the RUN entry tick T0, increments occur at ticks T0+STEP_FRAMES, T0+2·STEP_FRAMES, and so on.
- Releasing i_move for one tick restarts the STEP_FRAMES count from 0.
- Reset mid-RUN: all outputs reach reset values in the cycle after i_rst, regardless of i_frame_tick. Reset has priority over all other inputs.

## Test plan
- Reset then idle: assert i_rst 2 cycles, apply 20 ticks with i_move=0. Required: o_state=00 and o_score=0 throughout, o_inc_pulse never high.
- Paced increment (STEP_FRAMES=8): hold i_move from the IDLE→RUN tick for 24 further ticks. Required: o_score=3, o_tens=0, o_ones=3, and exactly 3 o_inc_pulse, each one cycle wide, on ticks 8, 16 and 24.
- BCD carry and saturation (STEP_FRAMES=1): hold i_move for 105 ticks in RUN.
  - The tick taking 9→10 yields tens=1, ones=0.
  - The score stops at 99 with tens=9, ones=9.
  - No pulse after reaching 99.
- Hold interruption: hold 7 ticks, release 1 tick, hold 7 ticks (STEP_FRAMES=8). Required: o_score unchanged at 0.
- Collision priority and high score: reach score 12, then assert i_collision and i_move on the same tick that would increment. Required:
  - o_state=10, o_score=12, o_high_score=12, no o_inc_pulse.
  - Then i_restart on a tick gives IDLE, score 0, high score 12.
  - A second game reaching 5 then colliding leaves o_high_score=12.
- Reset mid-game: at score 40 in RUN, assert i_rst off-tick. Required: next cycle all outputs zero, o_state=00, o_high_score=0.
